// File: rtl/pc_gen_if.sv
// Fetch-side bundle for pc_gen: next-PC select code, redirect targets and the
// fetch request handshake with its discard/pending/alignment flags.
interface pc_gen_if;
    logic [2:0]  PCSel;
    logic [31:0] JumpTarget;
    logic [31:0] EPC;
    logic [31:0] BranchTarget;
    logic [31:0] JRTarget;
    logic [31:0] PC_o;
    logic        PCValid_o;
    logic        PCReady_i;
    logic        Drop_o;
    logic        Redirect_Pending_o;
    logic        AdEL_o;

    modport master (
        input  PCSel, JumpTarget, EPC, BranchTarget, JRTarget, PCReady_i,
        output PC_o, PCValid_o, Drop_o, Redirect_Pending_o, AdEL_o
    );

    modport slave (
        output PCSel, JumpTarget, EPC, BranchTarget, JRTarget, PCReady_i,
        input  PC_o, PCValid_o, Drop_o, Redirect_Pending_o, AdEL_o
    );
endinterface

// File: rtl/pc_gen.sv
// Architectural fetch PC generator: decodes the IF next-PC select code, issues the
// PC over a valid/ready port and buffers redirects that land while the port stalls.
module pc_gen #(
    parameter logic [31:0] RESET_PC   = 32'hBFC0_0000,
    parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380
) (
    input  logic     clk,
    input  logic     rst,
    pc_gen_if.master bus
);

    typedef enum logic [1:0] {
        BOOT = 2'b00,
        RUN  = 2'b01,
        HOLD = 2'b10
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_tgt_q, pend_tgt_d;
    logic        pend_exc_q, pend_exc_d;
    logic        valid_q, valid_d;

    logic        redir_s;
    logic        exc_s;
    logic [31:0] tgt_s;
    logic        take_s;
    logic        merge_valid_s;
    logic        merge_exc_s;
    logic [31:0] merge_tgt_s;
    logic [31:0] pc_plus4_s;
    logic        fire_s;
    logic        drop_s;

    assign pc_plus4_s = pc_q + 32'd4;
    assign fire_s     = valid_q & bus.PCReady_i;

    // Select-code decode; reserved and unknown codes fall through as sequential.
    always_comb begin
        redir_s = 1'b0;
        exc_s   = 1'b0;
        tgt_s   = 32'h0000_0000;
        case (bus.PCSel)
            3'b001: begin
                redir_s = 1'b1;
                tgt_s   = bus.JumpTarget;
            end
            3'b010: begin
                redir_s = 1'b1;
                exc_s   = 1'b1;
                tgt_s   = bus.EPC;
            end
            3'b011: begin
                redir_s = 1'b1;
                exc_s   = 1'b1;
                tgt_s   = EXC_VECTOR;
            end
            3'b100: begin
                redir_s = 1'b1;
                tgt_s   = bus.BranchTarget;
            end
            3'b101: begin
                redir_s = 1'b1;
                tgt_s   = bus.JRTarget;
            end
            default: begin
                redir_s = 1'b0;
                exc_s   = 1'b0;
                tgt_s   = 32'h0000_0000;
            end
        endcase
    end

    // Merge the incoming redirect with the buffer; control flow never displaces a
    // buffered exception/eret, otherwise the newest redirect wins.
    always_comb begin
        take_s        = redir_s & ((state_q != HOLD) | exc_s | ~pend_exc_q);
        merge_valid_s = take_s | (state_q == HOLD);
        if (take_s) begin
            merge_tgt_s = tgt_s;
            merge_exc_s = exc_s;
        end else begin
            merge_tgt_s = pend_tgt_q;
            merge_exc_s = pend_exc_q;
        end
    end

    // Next-state, next-PC and wrong-path discard flag.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_tgt_d = pend_tgt_q;
        pend_exc_d = pend_exc_q;
        valid_d    = valid_q;
        drop_s     = 1'b0;
        case (state_q)
            BOOT: begin
                state_d = RUN;
                valid_d = 1'b1;
            end
            RUN, HOLD: begin
                if (merge_valid_s) begin
                    if (fire_s) begin
                        pc_d       = merge_tgt_s;
                        drop_s     = (merge_tgt_s != pc_plus4_s);
                        state_d    = RUN;
                        pend_tgt_d = 32'h0000_0000;
                        pend_exc_d = 1'b0;
                    end else begin
                        pend_tgt_d = merge_tgt_s;
                        pend_exc_d = merge_exc_s;
                        state_d    = HOLD;
                    end
                end else if (fire_s) begin
                    pc_d = pc_plus4_s;
                end else begin
                    pc_d = pc_q;
                end
            end
            default: begin
                state_d = BOOT;
                valid_d = 1'b0;
            end
        endcase
    end

    // State, PC and redirect buffer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            pend_tgt_q <= 32'h0000_0000;
            pend_exc_q <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_tgt_q <= pend_tgt_d;
            pend_exc_q <= pend_exc_d;
            valid_q    <= valid_d;
        end
    end

    assign bus.PC_o               = pc_q;
    assign bus.PCValid_o          = valid_q;
    assign bus.Drop_o             = drop_s;
    assign bus.Redirect_Pending_o = (state_q == HOLD);
    assign bus.AdEL_o             = (pc_q[1:0] != 2'b00);

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: stimulus queues the expected {PC_o, Drop_o} for every
// cycle it expects a fire; a negedge monitor pops and compares on each actual fire.
module tb_pc_gen;
    logic clk;
    logic rst;
    pc_gen_if bus ();

    pc_gen dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors   = 0;
    int miscomp   = 0;
    logic [32:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscomp++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Drive one cycle; if rdy, the DUT is expected to fire with the given PC/Drop.
    task automatic drive(input logic [2:0] sel, input logic rdy,
                         input logic [31:0] exp_pc, input logic exp_drop);
        bus.PCSel     = sel;
        bus.PCReady_i = rdy;
        if (rdy) exp_q.push_back({exp_pc, exp_drop});
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst && bus.PCValid_o && bus.PCReady_i) begin
            logic [32:0] e;
            vectors++;
            if (exp_q.size() == 0) begin
                miscomp++;
                $display("FAIL unexpected_fire: got pc=%08h drop=%0b expected no fire",
                         bus.PC_o, bus.Drop_o);
            end else begin
                e = exp_q.pop_front();
                if ({bus.PC_o, bus.Drop_o} !== e) begin
                    miscomp++;
                    $display("FAIL fire: got pc=%08h drop=%0b expected pc=%08h drop=%0b",
                             bus.PC_o, bus.Drop_o, e[32:1], e[0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.PCSel = 3'b000;
        bus.PCReady_i = 1'b1;
        bus.JumpTarget = 32'h0;
        bus.EPC = 32'h0;
        bus.BranchTarget = 32'h0;
        bus.JRTarget = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_pc", bus.PC_o, 32'hBFC0_0000);
        chk("reset_valid", {31'd0, bus.PCValid_o}, 32'd0);
        chk("reset_pending", {31'd0, bus.Redirect_Pending_o}, 32'd0);
        chk("reset_drop", {31'd0, bus.Drop_o}, 32'd0);
        rst = 1'b0;
        #1;
        chk("boot_valid", {31'd0, bus.PCValid_o}, 32'd0);
        @(posedge clk);
        #1;
        chk("run_valid", {31'd0, bus.PCValid_o}, 32'd1);
        drive(3'b000, 1'b1, 32'hBFC0_0000, 1'b0);
        drive(3'b000, 1'b1, 32'hBFC0_0004, 1'b0);
        drive(3'b000, 1'b1, 32'hBFC0_0008, 1'b0);
        // Jump to 8000_0100, then branch in a fire cycle.
        bus.JumpTarget = 32'h8000_0100;
        drive(3'b001, 1'b1, 32'hBFC0_000C, 1'b1);
        bus.BranchTarget = 32'h8000_0200;
        drive(3'b100, 1'b1, 32'h8000_0100, 1'b1);
        chk("branch_pc", bus.PC_o, 32'h8000_0200);
        // JR during stall, buffered for three cycles.
        bus.JRTarget = 32'h8000_1000;
        drive(3'b101, 1'b0, 32'h0, 1'b0);
        chk("jr_pending", {31'd0, bus.Redirect_Pending_o}, 32'd1);
        chk("jr_hold_pc", bus.PC_o, 32'h8000_0200);
        drive(3'b000, 1'b0, 32'h0, 1'b0);
        drive(3'b000, 1'b0, 32'h0, 1'b0);
        chk("jr_hold_pc2", bus.PC_o, 32'h8000_0200);
        drive(3'b000, 1'b1, 32'h8000_0200, 1'b1);
        chk("jr_pc", bus.PC_o, 32'h8000_1000);
        chk("jr_cleared", {31'd0, bus.Redirect_Pending_o}, 32'd0);
        // Buffered exception is not displaced by a later branch.
        drive(3'b011, 1'b0, 32'h0, 1'b0);
        bus.BranchTarget = 32'h8000_2000;
        drive(3'b100, 1'b0, 32'h0, 1'b0);
        drive(3'b000, 1'b1, 32'h8000_1000, 1'b1);
        chk("exc_prio_pc", bus.PC_o, 32'hBFC0_0380);
        // Same class: newest control-flow redirect wins.
        bus.JumpTarget = 32'h8000_3000;
        drive(3'b001, 1'b0, 32'h0, 1'b0);
        bus.JRTarget = 32'h8000_4000;
        drive(3'b101, 1'b0, 32'h0, 1'b0);
        drive(3'b000, 1'b1, 32'hBFC0_0380, 1'b1);
        chk("newest_pc", bus.PC_o, 32'h8000_4000);
        // Buffered branch overridden by eret presented in the fire cycle.
        drive(3'b100, 1'b0, 32'h0, 1'b0);
        bus.EPC = 32'h8000_5000;
        drive(3'b010, 1'b1, 32'h8000_4000, 1'b1);
        chk("eret_merge_pc", bus.PC_o, 32'h8000_5000);
        // 32-bit wrap, then misaligned jump.
        bus.JumpTarget = 32'hFFFF_FFFC;
        drive(3'b001, 1'b1, 32'h8000_5000, 1'b1);
        chk("adel_aligned", {31'd0, bus.AdEL_o}, 32'd0);
        drive(3'b000, 1'b1, 32'hFFFF_FFFC, 1'b0);
        chk("wrap_pc", bus.PC_o, 32'h0000_0000);
        bus.JumpTarget = 32'h8000_0002;
        drive(3'b001, 1'b1, 32'h0000_0000, 1'b1);
        chk("adel_pc", bus.PC_o, 32'h8000_0002);
        chk("adel", {31'd0, bus.AdEL_o}, 32'd1);
        // Reserved code acts as sequential.
        drive(3'b110, 1'b1, 32'h8000_0002, 1'b0);
        chk("reserved_pc", bus.PC_o, 32'h8000_0006);
        // Asynchronous reset while a redirect is buffered.
        bus.JRTarget = 32'h8000_7000;
        drive(3'b101, 1'b0, 32'h0, 1'b0);
        chk("hold_before_rst", {31'd0, bus.Redirect_Pending_o}, 32'd1);
        rst = 1'b1;
        #1;
        chk("async_rst_pc", bus.PC_o, 32'hBFC0_0000);
        chk("async_rst_pending", {31'd0, bus.Redirect_Pending_o}, 32'd0);
        bus.PCSel = 3'b000;
        bus.PCReady_i = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("reboot_valid", {31'd0, bus.PCValid_o}, 32'd0);
        @(posedge clk);
        #1;
        drive(3'b000, 1'b1, 32'hBFC0_0000, 1'b0);
        chk("reboot_pc", bus.PC_o, 32'hBFC0_0004);
        bus.PCReady_i = 1'b0;
        @(negedge clk);
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscomp);
        $finish;
    end
endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Consumer end of the 3-bit next-PC select code produced in IF.
- Holds the architectural fetch PC and issues it to the instruction-fetch port with a valid/ready handshake.
- Decodes the select code into the next PC: sequential, immediate jump, branch, JR, EPC, or exception vector.
- Buffers a redirect that arrives while the fetch port is stalled, and flags the stale fetch for discard.

Parameters:
- RESET_PC, 32'hBFC0_0000, PC loaded on reset.
- EXC_VECTOR, 32'hBFC0_0380, target for select code 3'b011.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-high reset.
- PCSel  in  3  select code: 000 PC+4, 001 immediate jump, 010 EPC, 011 exception, 100 branch, 101 JR; 110/111 reserved.
- JumpTarget  in  32  target for 001.
- EPC  in  32  target for 010.
- BranchTarget  in  32  target for 100.
- JRTarget  in  32  target for 101.
- PC_o  out  32  fetch address.
- PCValid_o  out  1  fetch request valid.
- PCReady_i  in  1  fetch port accepts.
- Drop_o  out  1  the request accepted this cycle is wrong-path; IF discards its response.
- Redirect_Pending_o  out  1  a redirect is buffered.
- AdEL_o  out  1  PC_o[1:0] != 2'b00.

Behaviour:
- Reset: asynchronous, immediate.
  - PC_o = RESET_PC, PCValid_o = 0, Drop_o = 0, Redirect_Pending_o = 0, state = BOOT.
  - Reset mid-operation discards any pending redirect.
- States: BOOT, RUN, HOLD.
  - BOOT -> RUN after exactly one clock; PCValid_o rises the first cycle after reset release.
  - RUN: no redirect buffered. HOLD: redirect buffered (Redirect_Pending_o = 1).
- Fire = PCValid_o & PCReady_i. While PCValid_o = 1 and PCReady_i = 0, PC_o must remain stable.
- Redirect = PCSel in {001, 010, 011, 100, 101}. Reserved codes 110/111 and X are treated as 000. PCSel is sampled every cycle in RUN/HOLD; it is ignored in BOOT.
- RUN, no redirect:
  - Fire -> PC_o <= PC_o + 4 (32-bit wrap, carry discarded), Drop_o = 0.
  - No fire -> hold.
- RUN, redirect, fire same cycle:
  - PC_o <= target; Drop_o = 1 in that cycle; stay in RUN.
- RUN, redirect, no fire:
  - Latch target and class into the pending buffer; go to HOLD; PC_o unchanged.
- HOLD, fire:
  - PC_o <= pending target (or newer higher-priority target, see below); Drop_o = 1; go to RUN; buffer cleared.
  - Any PCSel redirect presented in the same cycle merges per priority before the update.
- Priority classes: exception/eret (010, 011) > control flow (001, 100, 101).
  - A higher or equal class overwrites the buffer; newest wins within a class.
  - A lower class never overwrites a buffered exception/eret.
- Drop_o is combinational from state and inputs. It is high only in a fire cycle where the next PC is not PC_o + 4.
- AdEL_o is combinational from PC_o. The block never stalls on it; trap handling is downstream.
- Latency: a redirect that is accepted with fire appears on PC_o the next cycle. The buffer adds no extra cycle beyond the stall.

Test Plan:
- Reset, PCReady_i = 1, PCSel = 000: PC_o = BFC0_0000 with PCValid_o = 0 for 1 cycle, then BFC0_0000, BFC0_0004, BFC0_0008 on consecutive cycles, Drop_o = 0.
- PC_o = 8000_0100, PCReady_i = 1, PCSel = 100, BranchTarget = 8000_0200: Drop_o = 1 that cycle; next PC_o = 8000_0200.
- PCReady_i = 0, PCSel = 101 with JRTarget = 8000_1000 for one cycle, then ready after 3 cycles: PC_o holds, Redirect_Pending_o = 1; on fire Drop_o = 1; next PC_o = 8000_1000.
- Stall, PCSel = 011, then next cycle PCSel = 100 (target 8000_2000), then fire: next PC_o = BFC0_0380 (branch does not override exception).
- PC_o = FFFF_FFFC, fire, PCSel = 000: next PC_o = 0000_0000. PCSel = 001 with JumpTarget = 8000_0002: AdEL_o = 1 after the update.
- Assert rst while in HOLD: PC_o = BFC0_0000, Redirect_Pending_o = 0 immediately (no clock edge); after release, the BOOT sequence repeats.
